// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - rebuilds four digits from a multiplexed active-low 7-segment scan bus.
// Optional saturating select-error counter: define SEG_SCAN_CAPTURE_ERRCNT_EN.
module seg_scan_capture #(
  parameter int STABLE_CNT = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seg_sel,
  input  logic [6:0] seg_data,
  output logic [6:0] digit_raw_0,
  output logic [6:0] digit_raw_1,
  output logic [6:0] digit_raw_2,
  output logic [6:0] digit_raw_3,
  output logic [3:0] digit_hex_0,
  output logic [3:0] digit_hex_1,
  output logic [3:0] digit_hex_2,
  output logic [3:0] digit_hex_3,
  output logic [3:0] digit_valid,
  output logic [3:0] digit_fresh,
  output logic       frame_done,
  output logic       sel_err,
  output logic [7:0] err_count
);

  localparam logic [7:0]  STABLE_TH  = 8'(STABLE_CNT);
  localparam logic [15:0] TIMEOUT_TH = 16'(TIMEOUT);

  logic [5:0]  sel_q, sel_q2;
  logic [6:0]  data_q, data_q2;
  logic [7:0]  run_cnt;
  logic [6:0]  raw_r   [4];
  logic [3:0]  hex_r   [4];
  logic [15:0] tmo_cnt [4];
  logic [3:0]  valid_r, fresh_r, seen;
  logic [3:0]  sel_hit, cap, seen_next;
  logic        sel_illegal, stable;
  logic [4:0]  glyph;

  // Returns {valid, hex} for an active-low segment pattern.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Stage 1 registers the bus; stage 2 holds the pair together with its run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= 6'h3F;
      data_q  <= 7'h7F;
      sel_q2  <= 6'h3F;
      data_q2 <= 7'h7F;
      run_cnt <= 8'd0;
    end else begin
      sel_q   <= seg_sel;
      data_q  <= seg_data;
      sel_q2  <= sel_q;
      data_q2 <= data_q;
      if ({sel_q, data_q} != {sel_q2, data_q2})
        run_cnt <= 8'd1;
      else if (run_cnt != 8'hFF)
        run_cnt <= run_cnt + 8'd1;
    end
  end

  always_comb begin
    sel_hit     = 4'b0000;
    sel_illegal = 1'b0;
    case (sel_q2)
      6'b011111: sel_hit = 4'b0001;
      6'b101111: sel_hit = 4'b0010;
      6'b110111: sel_hit = 4'b0100;
      6'b111011: sel_hit = 4'b1000;
      6'b111111: sel_hit = 4'b0000;
      default:   sel_illegal = 1'b1;
    endcase
  end

  assign stable    = (run_cnt >= STABLE_TH);
  assign cap       = stable ? sel_hit : 4'b0000;
  assign seen_next = seen | cap;
  assign glyph     = decode_glyph(data_q2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        raw_r[i]   <= 7'h7F;
        hex_r[i]   <= 4'h0;
        tmo_cnt[i] <= 16'd0;
      end
      valid_r    <= 4'b0000;
      fresh_r    <= 4'b0000;
      seen       <= 4'b0000;
      frame_done <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= sel_illegal;
      for (int i = 0; i < 4; i++) begin
        if (cap[i]) begin
          raw_r[i]   <= data_q2;
          hex_r[i]   <= glyph[3:0];
          valid_r[i] <= glyph[4];
          fresh_r[i] <= 1'b1;
          tmo_cnt[i] <= 16'd0;
        end else if (tmo_cnt[i] != TIMEOUT_TH) begin
          tmo_cnt[i] <= tmo_cnt[i] + 16'd1;
          if (tmo_cnt[i] + 16'd1 == TIMEOUT_TH)
            fresh_r[i] <= 1'b0;
        end
      end
      // The completing capture is folded into the pulse, so seen restarts empty.
      if (seen_next == 4'b1111) begin
        frame_done <= 1'b1;
        seen       <= 4'b0000;
      end else begin
        frame_done <= 1'b0;
        seen       <= seen_next;
      end
    end
  end

`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_r;
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_r <= 8'd0;
    else if (sel_illegal && err_cnt_r != 8'hFF)
      err_cnt_r <= err_cnt_r + 8'd1;
  end
  assign err_count = err_cnt_r;
`else
  assign err_count = 8'h00;
`endif

  assign digit_raw_0 = raw_r[0];
  assign digit_raw_1 = raw_r[1];
  assign digit_raw_2 = raw_r[2];
  assign digit_raw_3 = raw_r[3];
  assign digit_hex_0 = hex_r[0];
  assign digit_hex_1 = hex_r[1];
  assign digit_hex_2 = hex_r[2];
  assign digit_hex_3 = hex_r[3];
  assign digit_valid = valid_r;
  assign digit_fresh = fresh_r;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - checks two seg_scan_capture builds against a bus-history reference model.
// Expected values come from the recorded bus history, not from the RTL pipeline.
module tb_seg_scan_capture;

  localparam int NCYC = 4096;
  localparam logic [12:0] BLANK_PAIR = {6'h3F, 7'h7F};

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] seg_sel;
  logic [6:0] seg_data;

  logic [6:0] raw_o   [2][4];
  logic [3:0] hex_o   [2][4];
  logic [3:0] valid_o [2];
  logic [3:0] fresh_o [2];
  logic       fd_o    [2];
  logic       se_o    [2];
  logic [7:0] ec_o    [2];

  always #5 clk = ~clk;

  seg_scan_capture #(.STABLE_CNT(1), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst), .seg_sel(seg_sel), .seg_data(seg_data),
    .digit_raw_0(raw_o[0][0]), .digit_raw_1(raw_o[0][1]),
    .digit_raw_2(raw_o[0][2]), .digit_raw_3(raw_o[0][3]),
    .digit_hex_0(hex_o[0][0]), .digit_hex_1(hex_o[0][1]),
    .digit_hex_2(hex_o[0][2]), .digit_hex_3(hex_o[0][3]),
    .digit_valid(valid_o[0]), .digit_fresh(fresh_o[0]),
    .frame_done(fd_o[0]), .sel_err(se_o[0]), .err_count(ec_o[0])
  );

  seg_scan_capture #(.STABLE_CNT(3), .TIMEOUT(20)) u_dut_b (
    .clk(clk), .rst(rst), .seg_sel(seg_sel), .seg_data(seg_data),
    .digit_raw_0(raw_o[1][0]), .digit_raw_1(raw_o[1][1]),
    .digit_raw_2(raw_o[1][2]), .digit_raw_3(raw_o[1][3]),
    .digit_hex_0(hex_o[1][0]), .digit_hex_1(hex_o[1][1]),
    .digit_hex_2(hex_o[1][2]), .digit_hex_3(hex_o[1][3]),
    .digit_valid(valid_o[1]), .digit_fresh(fresh_o[1]),
    .frame_done(fd_o[1]), .sel_err(se_o[1]), .err_count(ec_o[1])
  );

  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [5:0] digit_sel [4] = '{6'b011111, 6'b101111, 6'b110111, 6'b111011};
  int s_cnt [2] = '{1, 3};
  int t_out [2] = '{8, 20};

  logic [5:0] h_sel  [NCYC];
  logic [6:0] h_data [NCYC];
  bit         h_rst  [NCYC];
  int         t = -1;

  logic [6:0] m_raw   [2][4];
  int         m_cap_t [2][4];
  bit         m_has   [2][4];
  logic [3:0] m_seen  [2];
  bit         m_fd    [2];
  bit         m_se    [2];
  int         m_ec    [2];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [4:0] ref_glyph(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (glyphs[i] == p) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  // The pair that effectively reaches the capture stage from bus cycle k.
  function automatic logic [12:0] pair_at(input int k);
    if (h_rst[k] || h_rst[k+1]) return BLANK_PAIR;
    return {h_sel[k], h_data[k]};
  endfunction

  task automatic model_update();
    logic [12:0] pk;
    int run, idx;
    bit illegal;
    for (int d = 0; d < 2; d++) begin
      if (h_rst[t]) begin
        for (int i = 0; i < 4; i++) begin
          m_raw[d][i] = 7'h7F;
          m_has[d][i] = 1'b0;
          m_cap_t[d][i] = 0;
        end
        m_seen[d] = 4'b0;
        m_fd[d] = 1'b0;
        m_se[d] = 1'b0;
        m_ec[d] = 0;
      end else begin
        m_fd[d] = 1'b0;
        m_se[d] = 1'b0;
        if (t >= 2) begin
          pk = pair_at(t - 2);
          run = 0;
          for (int j = t - 2; j >= 0 && run < 255; j--) begin
            if (pair_at(j) != pk) break;
            run++;
          end
          idx = -1;
          for (int i = 0; i < 4; i++)
            if (pk[12:7] == digit_sel[i]) idx = i;
          illegal = (idx < 0) && (pk[12:7] != 6'h3F);
          if (illegal) begin
            m_se[d] = 1'b1;
            if (m_ec[d] < 255) m_ec[d]++;
          end else if (idx >= 0 && run >= s_cnt[d]) begin
            m_raw[d][idx] = pk[6:0];
            m_has[d][idx] = 1'b1;
            m_cap_t[d][idx] = t;
            m_seen[d][idx] = 1'b1;
            if (m_seen[d] == 4'b1111) begin
              m_fd[d] = 1'b1;
              m_seen[d] = 4'b0;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d t=%0d observed=%0h expected=%0h", tag, d, t, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0] g;
    logic [3:0] ev, ef;
    int eec;
    for (int d = 0; d < 2; d++) begin
      ev = 4'b0;
      ef = 4'b0;
      for (int i = 0; i < 4; i++) begin
        g = ref_glyph(m_raw[d][i]);
        ev[i] = g[4];
        ef[i] = m_has[d][i] && ((t - m_cap_t[d][i]) < t_out[d]);
        chk($sformatf("raw%0d", i), d, 16'(raw_o[d][i]), 16'(m_raw[d][i]));
        chk($sformatf("hex%0d", i), d, 16'(hex_o[d][i]), 16'(g[3:0]));
      end
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
      eec = m_ec[d];
`else
      eec = 0;
`endif
      chk("valid", d, 16'(valid_o[d]), 16'(ev));
      chk("fresh", d, 16'(fresh_o[d]), 16'(ef));
      chk("frame_done", d, 16'(fd_o[d]), 16'(m_fd[d]));
      chk("sel_err", d, 16'(se_o[d]), 16'(m_se[d]));
      chk("err_count", d, 16'(ec_o[d]), 16'(eec));
    end
  endtask

  task automatic tick(input logic r, input logic [5:0] s, input logic [6:0] dd);
    @(negedge clk);
    rst = r;
    seg_sel = s;
    seg_data = dd;
    @(posedge clk);
    if (t >= NCYC - 2) begin
      $display("FAIL cycle_budget t=%0d limit=%0d", t, NCYC - 2);
      $fatal(1);
    end
    t++;
    h_rst[t] = r;
    h_sel[t] = s;
    h_data[t] = dd;
    model_update();
    #1;
    check_all();
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 6'h3F, 7'h7F);
  endtask

  initial begin
    logic [6:0] rot_data [4];
    logic [5:0] rs;
    logic [6:0] rd;
    int hold;
    rot_data = '{7'h79, 7'h24, 7'h30, 7'h19};
    rst = 1'b1;
    seg_sel = 6'h3F;
    seg_data = 7'h7F;

    for (int i = 0; i < 3; i++) tick(1'b1, 6'h3F, 7'h7F);
    blank(2);

    // Rotating scan; after six edges digits read 1,2,3,4 on the STABLE_CNT=1 build.
    for (int i = 0; i < 4; i++) tick(1'b0, digit_sel[i], rot_data[i]);
    blank(2);
    chk("rot_hex0", 0, 16'(hex_o[0][0]), 16'h1);
    chk("rot_hex3", 0, 16'(hex_o[0][3]), 16'h4);
    chk("rot_valid", 0, 16'(valid_o[0]), 16'hF);
    chk("rot_fresh", 0, 16'(fresh_o[0]), 16'hF);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) tick(1'b0, digit_sel[i], rot_data[i]);
    blank(2);

    tick(1'b0, 6'b001111, 7'h40);
    tick(1'b0, 6'b001111, 7'h40);
    blank(3);

    tick(1'b0, digit_sel[0], 7'h12);
    tick(1'b0, digit_sel[0], 7'h12);
    blank(1);
    for (int i = 0; i < 3; i++) tick(1'b0, digit_sel[0], 7'h12);
    blank(3);
    chk("stable_hex0", 1, 16'(hex_o[1][0]), 16'h5);

    tick(1'b0, digit_sel[2], 7'h30);
    blank(12);

    tick(1'b0, digit_sel[3], 7'h7F);
    blank(2);
    tick(1'b0, digit_sel[3], 7'h55);
    blank(2);
    chk("glyph_valid3", 0, 16'(valid_o[0][3]), 16'h0);

    tick(1'b0, digit_sel[0], 7'h40);
    tick(1'b0, digit_sel[1], 7'h79);
    tick(1'b1, 6'h3F, 7'h7F);
    for (int i = 0; i < 4; i++) tick(1'b0, digit_sel[i], rot_data[i]);
    blank(2);

    while (t < 1600) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rs = digit_sel[$urandom_range(0, 3)];
        5, 6, 7:       rs = 6'h3F;
        default:       rs = 6'($urandom);
      endcase
      rd = ($urandom_range(0, 9) < 7) ? glyphs[$urandom_range(0, 15)] : 7'($urandom);
      hold = $urandom_range(1, 5);
      for (int i = 0; i < hold; i++)
        tick(($urandom_range(0, 199) == 0), rs, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
